// File: rtl/rate_limit_arb.sv
// Round-robin packet arbiter feeding the transmit rate limiter push port.
// Holds the grant for a whole packet, with stall-timeout and length-limit release.
module rate_limit_arb #(
  parameter int W         = 32,
  parameter int N_SRC     = 4,
  parameter int MAX_LEN   = 16,
  parameter int STALL_MAX = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_SRC-1:0]         src_valid,
  input  logic [N_SRC-1:0]         src_last,
  input  logic [N_SRC*W-1:0]       src_data,
  output logic [N_SRC-1:0]         src_ready,
  output logic                     tx_valid,
  output logic [W-1:0]             tx_data,
  input  logic                     tx_full_r,
  input  logic                     err_clr,
  output logic                     lock_r,
  output logic [$clog2(N_SRC)-1:0] owner_r,
  output logic                     err_stall_r,
  output logic                     err_len_r
);
  localparam int PW = $clog2(N_SRC);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, owner_q, owner_d, sel;
  logic [7:0]    len_q, len_d, stall_q, stall_d;
  logic          err_stall_q, err_stall_d, err_len_q, err_len_d;
  logic          cand, acc, eop, len_hit, stall_hit, set_stall, set_len;
  logic [W-1:0]  data_a [N_SRC];

  for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
    assign data_a[i] = src_data[i*W +: W];
  end

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
    if (v == PW'(N_SRC - 1)) return '0;
    return v + PW'(1);
  endfunction

  // Scan from the farthest candidate back to ptr so the nearest valid source wins.
  function automatic logic [PW-1:0] rr_pick(input logic [N_SRC-1:0] v, input logic [PW-1:0] p);
    logic [PW-1:0] s;
    logic [PW-1:0] idx;
    s = p;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      idx = PW'((int'(p) + k) % N_SRC);
      if (v[idx]) s = idx;
    end
    return s;
  endfunction

  always_comb begin
    sel  = ptr_q;
    cand = 1'b0;
    if (state_q == LOCK) begin
      sel  = owner_q;
      cand = src_valid[owner_q];
    end else begin
      sel  = rr_pick(src_valid, ptr_q);
      cand = |src_valid;
    end
  end

  assign acc       = cand & ~tx_full_r;
  assign len_hit   = ({1'b0, len_q} + 9'd1) == 9'(MAX_LEN);
  assign stall_hit = ({1'b0, stall_q} + 9'd1) == 9'(STALL_MAX);
  assign eop       = acc & (src_last[sel] | len_hit);
  assign set_len   = eop & ~src_last[sel];

  // Outputs are held quiet during reset so an abandoned packet emits nothing.
  assign tx_valid  = acc & rst_n;
  assign tx_data   = data_a[sel];
  assign src_ready = (acc & rst_n) ? (N_SRC'(1) << sel) : '0;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    len_d     = len_q;
    stall_d   = stall_q;
    set_stall = 1'b0;
    if (state_q == IDLE) begin
      if (eop) begin
        ptr_d = wrap_inc(sel);
      end else if (acc) begin
        state_d = LOCK;
        owner_d = sel;
        len_d   = 8'd1;
        stall_d = 8'd0;
      end
    end else begin
      if (eop) begin
        state_d = IDLE;
        ptr_d   = wrap_inc(owner_q);
        len_d   = 8'd0;
      end else if (acc) begin
        len_d   = len_q + 8'd1;
        stall_d = 8'd0;
      end else if (!src_valid[owner_q]) begin
        if (stall_hit) begin
          state_d   = IDLE;
          ptr_d     = wrap_inc(owner_q);
          len_d     = 8'd0;
          stall_d   = 8'd0;
          set_stall = 1'b1;
        end else begin
          stall_d = stall_q + 8'd1;
        end
      end
    end
    err_stall_d = set_stall | (err_stall_q & ~err_clr);
    err_len_d   = set_len   | (err_len_q   & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      len_q       <= 8'd0;
      stall_q     <= 8'd0;
      err_stall_q <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      len_q       <= len_d;
      stall_q     <= stall_d;
      err_stall_q <= err_stall_d;
      err_len_q   <= err_len_d;
    end
  end

  assign lock_r      = (state_q == LOCK);
  assign owner_r     = owner_q;
  assign err_stall_r = err_stall_q;
  assign err_len_r   = err_len_q;
endmodule

// File: tb/tb_rate_limit_arb.sv
// Bench for rate_limit_arb: two instances (MAX_LEN 16 and 3, STALL_MAX 4) checked
// every cycle against a packet-level reference model, plus directed scenarios.
module tb_rate_limit_arb;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int SM = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0]   sv [2];
  logic [N-1:0]   sl [2];
  logic [N*W-1:0] sd [2];
  logic           full [2];
  logic           clr [2];
  logic [N-1:0]   sr [2];
  logic           txv [2];
  logic [W-1:0]   txd [2];
  logic           lk [2];
  logic [1:0]     ow [2];
  logic           es [2];
  logic           el [2];

  always #5 clk = ~clk;

  rate_limit_arb #(.W(W), .N_SRC(N), .MAX_LEN(16), .STALL_MAX(SM)) u_a (
    .clk(clk), .rst_n(rst_n), .src_valid(sv[0]), .src_last(sl[0]), .src_data(sd[0]),
    .src_ready(sr[0]), .tx_valid(txv[0]), .tx_data(txd[0]), .tx_full_r(full[0]),
    .err_clr(clr[0]), .lock_r(lk[0]), .owner_r(ow[0]), .err_stall_r(es[0]), .err_len_r(el[0]));

  rate_limit_arb #(.W(W), .N_SRC(N), .MAX_LEN(3), .STALL_MAX(SM)) u_b (
    .clk(clk), .rst_n(rst_n), .src_valid(sv[1]), .src_last(sl[1]), .src_data(sd[1]),
    .src_ready(sr[1]), .tx_valid(txv[1]), .tx_data(txd[1]), .tx_full_r(full[1]),
    .err_clr(clr[1]), .lock_r(lk[1]), .owner_r(ow[1]), .err_stall_r(es[1]), .err_len_r(el[1]));

  int checks = 0;
  int failures = 0;

  // Reference model: cur = source holding the packet, or -1 when free.
  int cur [2];
  int nxt [2];
  int words [2];
  int idle [2];
  int mown [2];
  bit mes [2];
  bit mel [2];
  int maxl [2];
  int obs_g [2];
  logic [W-1:0] obs_d [2];
  int rem [2][N];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      cur[m] = -1; nxt[m] = 0; words[m] = 0; idle[m] = 0;
      mown[m] = 0; mes[m] = 0; mel[m] = 0;
    end
  endtask

  function automatic int pick(int m);
    if (full[m]) return -1;
    if (cur[m] >= 0) return sv[m][cur[m]] ? cur[m] : -1;
    for (int k = 0; k < N; k++)
      if (sv[m][(nxt[m] + k) % N]) return (nxt[m] + k) % N;
    return -1;
  endfunction

  task automatic model_step(int m, int g);
    bit st, ln, fin;
    int n;
    st = 0; ln = 0;
    if (g >= 0) begin
      n   = (cur[m] < 0) ? 1 : words[m] + 1;
      fin = sl[m][g] || (n == maxl[m]);
      ln  = !sl[m][g] && (n == maxl[m]);
      idle[m] = 0;
      if (fin) begin
        nxt[m] = (g + 1) % N; cur[m] = -1; words[m] = 0;
      end else begin
        if (cur[m] < 0) mown[m] = g;
        cur[m] = g; words[m] = n;
      end
    end else if (cur[m] >= 0 && !sv[m][cur[m]]) begin
      idle[m]++;
      if (idle[m] == SM) begin
        st = 1; nxt[m] = (cur[m] + 1) % N; cur[m] = -1; words[m] = 0; idle[m] = 0;
      end
    end
    mes[m] = st || (mes[m] && !clr[m]);
    mel[m] = ln || (mel[m] && !clr[m]);
  endtask

  // One clock: inputs already driven at the falling edge.
  task automatic cycle();
    int g [2];
    logic [N-1:0] er;
    #1;
    for (int m = 0; m < 2; m++) begin
      g[m] = pick(m);
      er = (g[m] >= 0) ? (N'(1) << g[m]) : '0;
      obs_g[m] = -1;
      for (int i = N - 1; i >= 0; i--) if (sr[m][i] === 1'b1) obs_g[m] = i;
      obs_d[m] = txd[m];
      checks++;
      if (txv[m] !== (g[m] >= 0)) begin
        failures++; $display("FAIL tx_valid dut=%0d got=%b exp=%b t=%0t", m, txv[m], g[m] >= 0, $time);
      end
      checks++;
      if (sr[m] !== er) begin
        failures++; $display("FAIL src_ready dut=%0d got=%b exp=%b t=%0t", m, sr[m], er, $time);
      end
      if (g[m] >= 0) begin
        checks++;
        if (txd[m] !== sd[m][g[m]*W +: W]) begin
          failures++; $display("FAIL tx_data dut=%0d got=%h exp=%h t=%0t", m, txd[m], sd[m][g[m]*W +: W], $time);
        end
      end
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) model_step(m, g[m]);
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (lk[m] !== (cur[m] >= 0)) begin
        failures++; $display("FAIL lock_r dut=%0d got=%b exp=%b t=%0t", m, lk[m], cur[m] >= 0, $time);
      end
      checks++;
      if (ow[m] !== 2'(mown[m])) begin
        failures++; $display("FAIL owner_r dut=%0d got=%0d exp=%0d t=%0t", m, ow[m], mown[m], $time);
      end
      checks++;
      if (es[m] !== mes[m]) begin
        failures++; $display("FAIL err_stall_r dut=%0d got=%b exp=%b t=%0t", m, es[m], mes[m], $time);
      end
      checks++;
      if (el[m] !== mel[m]) begin
        failures++; $display("FAIL err_len_r dut=%0d got=%b exp=%b t=%0t", m, el[m], mel[m], $time);
      end
    end
  endtask

  task automatic idle_all();
    for (int m = 0; m < 2; m++) begin
      sv[m] = '0; sl[m] = '0; sd[m] = '0; full[m] = 1'b0; clr[m] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_all();
    #2;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_all();
    sv[0] = '1; sl[0] = '1; sv[1] = '1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (txv[m] !== 1'b0 || sr[m] !== '0) begin
        failures++; $display("FAIL reset_outputs dut=%0d got=%b/%b exp=0/0", m, txv[m], sr[m]);
      end
      checks++;
      if ({lk[m], ow[m], es[m], el[m]} !== 5'b0) begin
        failures++; $display("FAIL reset_regs dut=%0d got=%b exp=00000", m, {lk[m], ow[m], es[m], el[m]});
      end
    end
    idle_all();
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    do_reset();
    sv[0] = 4'b1111; sl[0] = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++) sd[0][i*W +: W] = 32'hA000_0000 | (i << 8) | k;
      cycle();
      checks++;
      if (obs_g[0] !== k % 4 || obs_d[0] !== (32'hA000_0000 | ((k % 4) << 8) | k)) begin
        failures++; $display("FAIL rr_order k=%0d got=%0d/%h exp=%0d", k, obs_g[0], obs_d[0], k % 4);
      end
    end
  endtask

  task automatic test_packet_lock();
    do_reset();
    sv[0] = 4'b0010; sl[0] = 4'b0010; sd[0][1*W +: W] = 32'h11;
    cycle();
    checks++;
    if (obs_g[0] !== 1) begin failures++; $display("FAIL lock_pre got=%0d exp=1", obs_g[0]); end
    for (int k = 0; k < 5; k++) begin
      sv[0] = 4'b0101; sl[0] = (k == 4) ? 4'b0101 : 4'b0001;
      sd[0][0 +: W] = 32'h0A; sd[0][2*W +: W] = 32'h2000 + k;
      cycle();
      checks++;
      if (obs_g[0] !== 2 || obs_d[0] !== 32'h2000 + k) begin
        failures++; $display("FAIL lock_grant k=%0d got=%0d/%h exp=2/%h", k, obs_g[0], obs_d[0], 32'h2000 + k);
      end
      checks++;
      if (lk[0] !== (k < 4)) begin failures++; $display("FAIL lock_flag k=%0d got=%b exp=%b", k, lk[0], k < 4); end
    end
    sv[0] = 4'b0001;
    cycle();
    checks++;
    if (obs_g[0] !== 0) begin failures++; $display("FAIL lock_next got=%0d exp=0", obs_g[0]); end
  endtask

  task automatic test_backpressure();
    int k;
    do_reset();
    k = 0;
    for (int c = 0; c < 17; c++) begin
      sv[0] = (k < 6) ? 4'b1010 : 4'b1000;
      sl[0] = (k == 5) ? 4'b1010 : 4'b1000;
      sd[0][1*W +: W] = 32'hB000 + k; sd[0][3*W +: W] = 32'h33;
      full[0] = (c >= 2 && c < 12);
      cycle();
      checks++;
      if (c < 16 && obs_g[0] !== (full[0] ? -1 : 1)) begin
        failures++; $display("FAIL bp_grant c=%0d got=%0d exp=%0d", c, obs_g[0], full[0] ? -1 : 1);
      end else if (c == 16 && obs_g[0] !== 3) begin
        failures++; $display("FAIL bp_after got=%0d exp=3", obs_g[0]);
      end
      if (c < 16 && !full[0]) begin
        checks++;
        if (obs_d[0] !== 32'hB000 + k) begin
          failures++; $display("FAIL bp_word k=%0d got=%h exp=%h", k, obs_d[0], 32'hB000 + k);
        end
        k++;
      end
      if (c < 16) begin
        checks++;
        if (lk[0] !== (c < 15)) begin failures++; $display("FAIL bp_lock c=%0d got=%b exp=%b", c, lk[0], c < 15); end
      end
    end
  endtask

  task automatic test_stall_timeout();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      sv[0] = (c < 2) ? 4'b0011 : ((c < 7) ? 4'b0010 : 4'b0000);
      sl[0] = 4'b0010;
      sd[0][0 +: W] = 32'hD000 + c; sd[0][1*W +: W] = 32'h55;
      clr[0] = (c == 7);
      cycle();
      if (c < 7) begin
        checks++;
        if (obs_g[0] !== ((c < 2) ? 0 : (c == 6) ? 1 : -1)) begin
          failures++; $display("FAIL stall_grant c=%0d got=%0d", c, obs_g[0]);
        end
      end
      checks++;
      if (lk[0] !== (c < 5)) begin failures++; $display("FAIL stall_lock c=%0d got=%b exp=%b", c, lk[0], c < 5); end
      checks++;
      if (es[0] !== (c >= 5 && c < 7)) begin
        failures++; $display("FAIL stall_err c=%0d got=%b exp=%b", c, es[0], c >= 5 && c < 7);
      end
    end
    clr[0] = 1'b0;
  endtask

  task automatic test_len_overflow();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      sv[1] = 4'b0100; sl[1] = (k == 4) ? 4'b0100 : 4'b0000;
      sd[1][2*W +: W] = 32'hC000 + k;
      cycle();
      checks++;
      if (obs_g[1] !== 2 || obs_d[1] !== 32'hC000 + k) begin
        failures++; $display("FAIL len_word k=%0d got=%0d/%h exp=2/%h", k, obs_g[1], obs_d[1], 32'hC000 + k);
      end
      checks++;
      if (lk[1] !== (k == 0 || k == 1 || k == 3)) begin
        failures++; $display("FAIL len_lock k=%0d got=%b", k, lk[1]);
      end
      checks++;
      if (el[1] !== (k >= 2)) begin failures++; $display("FAIL len_err k=%0d got=%b exp=%b", k, el[1], k >= 2); end
    end
    sv[1] = '0; clr[1] = 1'b1;
    cycle();
    checks++;
    if (el[1] !== 1'b0) begin failures++; $display("FAIL len_clr got=%b exp=0", el[1]); end
    clr[1] = 1'b0;
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    sv[0] = 4'b1000; sl[0] = '0; sd[0][3*W +: W] = 32'hE0;
    cycle();
    checks++;
    if (obs_g[0] !== 3 || lk[0] !== 1'b1) begin failures++; $display("FAIL rstmid_pre got=%0d/%b exp=3/1", obs_g[0], lk[0]); end
    sd[0][3*W +: W] = 32'hE1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (txv[0] !== 1'b0 || sr[0] !== '0 || lk[0] !== 1'b0) begin
      failures++; $display("FAIL rstmid_async got=%b/%b/%b exp=0/0/0", txv[0], sr[0], lk[0]);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    sv[0] = 4'b1010; sl[0] = 4'b1010; sd[0][1*W +: W] = 32'h77;
    cycle();
    checks++;
    if (obs_g[0] !== 1) begin failures++; $display("FAIL rstmid_restart got=%0d exp=1", obs_g[0]); end
    cycle();
    checks++;
    if (obs_g[0] !== 3) begin failures++; $display("FAIL rstmid_next got=%0d exp=3", obs_g[0]); end
  endtask

  task automatic test_random();
    do_reset();
    for (int m = 0; m < 2; m++) for (int i = 0; i < N; i++) rem[m][i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int m = 0; m < 2; m++) begin
        for (int i = 0; i < N; i++) begin
          if (!(sv[m][i] && obs_g[m] != i)) begin
            if (sv[m][i] && obs_g[m] == i) rem[m][i]--;
            if (rem[m][i] == 0 && $urandom_range(0, 3) == 0) rem[m][i] = $urandom_range(1, 6);
            sv[m][i] = (rem[m][i] > 0) && ($urandom_range(0, 1) == 1);
            sl[m][i] = (rem[m][i] == 1);
            sd[m][i*W +: W] = $urandom;
          end
        end
        full[m] = ($urandom_range(0, 4) == 0);
        clr[m]  = ($urandom_range(0, 15) == 0);
      end
      cycle();
    end
  endtask

  initial begin
    maxl[0] = 16; maxl[1] = 3;
    obs_g[0] = -1; obs_g[1] = -1;
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_stall_timeout();
    test_len_overflow();
    test_reset_mid_packet();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
